// File: rtl/divisor_8bits_pkg.sv
// Shared widths, FSM encoding and operand/result bundles for the 8/4 restoring divider.
// Optional divide-by-zero flag is selected by DIVISOR_DIV0_ERR_EN.
package divisor_8bits_pkg;

  localparam int N_DIVIDENDO = 8;
  localparam int N_DIVISOR   = 4;
  localparam int ITERACIONES = 8;
  localparam int N_CNT       = 3;
  localparam int N_PARCIAL   = N_DIVISOR + 1;

  localparam logic [N_CNT-1:0] ULTIMA_ITER = N_CNT'(ITERACIONES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic [N_DIVIDENDO-1:0] dividendo;
    logic [N_DIVISOR-1:0]   divisor;
  } operandos_t;

  typedef struct packed {
    logic [N_DIVIDENDO-1:0] cociente;
    logic [N_DIVISOR-1:0]   residuo;
  } resultado_t;

  // Partial remainder after shifting in the next dividend bit.
  function automatic logic [N_PARCIAL-1:0] desplaza_parcial(
      input logic [N_PARCIAL-1:0] parcial,
      input logic                 bit_entrada);
    return {parcial[N_DIVISOR-1:0], bit_entrada};
  endfunction

endpackage

// File: rtl/divisor_8bits_if.sv
// Start/busy/done handshake and operand/result bus between the lab top and the divider.
// err_div0 exists only when DIVISOR_DIV0_ERR_EN is defined.
interface divisor_8bits_if;
  import divisor_8bits_pkg::*;

  logic                   start;
  logic [N_DIVIDENDO-1:0] dividendo;
  logic [N_DIVISOR-1:0]   divisor;
  logic [N_DIVIDENDO-1:0] cociente;
  logic [N_DIVISOR-1:0]   residuo;
  logic                   busy;
  logic                   done;
`ifdef DIVISOR_DIV0_ERR_EN
  logic                   err_div0;

  modport master (
    output start, dividendo, divisor,
    input  cociente, residuo, busy, done, err_div0
  );

  modport slave (
    input  start, dividendo, divisor,
    output cociente, residuo, busy, done, err_div0
  );
`else
  modport master (
    output start, dividendo, divisor,
    input  cociente, residuo, busy, done
  );

  modport slave (
    input  start, dividendo, divisor,
    output cociente, residuo, busy, done
  );
`endif

endinterface

// File: rtl/divisor_8bits_restador_5bits.sv
// Combinational 5-bit trial subtractor, ripple-borrow chain of full subtractors.
// borrow=0 means a >= b: the quotient bit is 1 and the difference replaces the remainder.
module restador_5bits
  import divisor_8bits_pkg::*;
(
  input  logic [N_PARCIAL-1:0] a,
  input  logic [N_PARCIAL-1:0] b,
  output logic [N_PARCIAL-1:0] diff,
  output logic                 borrow
);

  logic [N_PARCIAL:0] bw;

  assign bw[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < N_PARCIAL; i++) begin : g_etapa
      logic x;
      assign x          = a[i] ^ b[i];
      assign diff[i]    = x ^ bw[i];
      assign bw[i+1]    = (~a[i] & b[i]) | (~x & bw[i]);
    end
  endgenerate

  assign borrow = bw[N_PARCIAL];

endmodule

// File: rtl/divisor_8bits.sv
// Restoring divider 8/4: one quotient bit per clock MSB first; DIVISOR_DIV0_ERR_EN adds a 1-cycle div-by-zero flag.
// Latency 8 cycles start->done; no backpressure, start is ignored while busy.
module divisor_8bits
  import divisor_8bits_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  divisor_8bits_if.slave  bus
);

  state_t                 state, state_nxt;
  logic [N_CNT-1:0]       cnt;
  logic [N_DIVIDENDO-1:0] d_reg;
  logic [N_DIVIDENDO-1:0] q_reg;
  logic [N_DIVISOR-1:0]   div_reg;
  logic [N_PARCIAL-1:0]   r_reg;
  resultado_t             res_reg;

  logic                   accept;
  logic                   zero_div;
  logic                   ultima;
  logic [N_PARCIAL-1:0]   r5;
  logic [N_PARCIAL-1:0]   diff;
  logic [N_PARCIAL-1:0]   r_nxt;
  logic                   borrow;
  logic                   qbit;
  operandos_t             op_in;

  assign op_in  = '{dividendo: bus.dividendo, divisor: bus.divisor};
  assign ultima = (cnt == ULTIMA_ITER);

  assign r5 = desplaza_parcial(r_reg, d_reg[N_DIVIDENDO-1]);

  restador_5bits u_restador (
    .a      (r5),
    .b      ({1'b0, div_reg}),
    .diff   (diff),
    .borrow (borrow)
  );

  // No borrow: keep the difference; otherwise restore by keeping r5.
  assign qbit  = ~borrow;
  assign r_nxt = borrow ? r5 : diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    zero_div  = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
`ifdef DIVISOR_DIV0_ERR_EN
          if (op_in.divisor == '0) begin
            zero_div  = 1'b1;
            state_nxt = DONE;
          end
`endif
        end
      end
      RUN: begin
        if (ultima) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      d_reg   <= '0;
      q_reg   <= '0;
      div_reg <= '0;
      r_reg   <= '0;
      res_reg <= '0;
    end else if (accept) begin
      cnt     <= '0;
      d_reg   <= op_in.dividendo;
      div_reg <= op_in.divisor;
      q_reg   <= '0;
      r_reg   <= '0;
      if (zero_div) begin
        res_reg <= '0;
      end
    end else if (state == RUN) begin
      cnt     <= cnt + N_CNT'(1);
      d_reg   <= {d_reg[N_DIVIDENDO-2:0], 1'b0};
      r_reg   <= r_nxt;
      q_reg   <= {q_reg[N_DIVIDENDO-2:0], qbit};
      // The final remainder is below the divisor, so the low 4 bits hold it exactly.
      if (ultima) begin
        res_reg <= '{cociente: {q_reg[N_DIVIDENDO-2:0], qbit},
                     residuo:  r_nxt[N_DIVISOR-1:0]};
      end
    end
  end

`ifdef DIVISOR_DIV0_ERR_EN
  logic err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (accept) begin
      err_reg <= zero_div;
    end
  end

  assign bus.err_div0 = err_reg & (state == DONE);
`endif

  assign bus.cociente = res_reg.cociente;
  assign bus.residuo  = res_reg.residuo;
  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_divisor_8bits.sv
// Randomized and directed bench for divisor_8bits: a driver pushes expected results from a / and % model,
// a negedge monitor pops and compares each done pulse (value, error flag and latency).
module tb_divisor_8bits;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       err;
    int         lat;
    int         t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   busy_cnt = 0;
  exp_t sb[$];

  divisor_8bits_if bus ();

  divisor_8bits dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (!rst && bus.busy) busy_cnt <= busy_cnt + 1;

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.err = 1'b0;
    e.lat = 8;
    e.t0  = 0;
    if (b == 0) begin
`ifdef DIVISOR_DIV0_ERR_EN
      e.q = 8'h00; e.r = 4'h0; e.err = 1'b1; e.lat = 1;
`else
      e.q = 8'hFF; e.r = 4'(a % 16);
`endif
    end else begin
      e.q = 8'(a / b);
      e.r = 4'(a % b);
    end
    return e;
  endfunction

  function automatic logic err_act();
`ifdef DIVISOR_DIV0_ERR_EN
    return bus.err_div0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  // Monitor: every done pulse is a comparison against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: got q=%0d r=%0d at cycle %0d, want no done", bus.cociente, bus.residuo, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.cociente !== e.q || bus.residuo !== e.r || err_act() !== e.err || (cyc - e.t0) != e.lat) begin
          n_bad++;
          $display("FAIL result: got q=%0d r=%0d err=%0b lat=%0d, want q=%0d r=%0d err=%0b lat=%0d",
                   bus.cociente, bus.residuo, err_act(), cyc - e.t0, e.q, e.r, e.err, e.lat);
        end
      end
    end
  end

  task automatic issue(input int a, input int b);
    exp_t e;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.dividendo = 8'(a);
    bus.divisor   = 4'(b);
    @(posedge clk);
    #1;
    e    = model(a, b);
    e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int w = 0;
    while (sb.size() != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: got %0d pending results, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic div(input int a, input int b);
    issue(a, b);
    wait_done();
  endtask

  initial begin
    int b0;
    exp_t e;
    bus.start     = 1'b0;
    bus.dividendo = '0;
    bus.divisor   = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cociente", bus.cociente, 0);
    chk("rst_residuo", bus.residuo, 0);
    chk("rst_err", err_act(), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    b0 = busy_cnt;
    div(200, 7);
    chk("busy_cycles_200_7", busy_cnt - b0, 8);
    div(255, 1);
    div(5, 9);
    div(0, 15);

    for (int a = 1; a <= 15; a++)
      for (int b = 1; b <= 15; b++)
        div(a * b, b);

    for (int i = 0; i < 60; i++)
      div(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));

    // Start held through RUN with operands changed, re-accepted in the DONE cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.dividendo = 8'd200; bus.divisor = 4'd7;
    @(posedge clk);
    #1;
    e = model(200, 7); e.t0 = cyc; sb.push_back(e);
    @(negedge clk);
    bus.dividendo = 8'd99; bus.divisor = 4'd3;
    repeat (9) @(posedge clk);
    #1;
    e = model(99, 3); e.t0 = cyc; sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Asynchronous reset with counter at 4: outputs clear immediately, no done follows.
    issue(200, 7);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_cociente", bus.cociente, 0);
    chk("midrst_residuo", bus.residuo, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    div(123, 11);

    b0 = busy_cnt;
    div(8'hA7, 0);
`ifdef DIVISOR_DIV0_ERR_EN
    chk("busy_cycles_div0", busy_cnt - b0, 0);
`else
    chk("busy_cycles_div0", busy_cnt - b0, 8);
`endif
    div(100, 6);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
